tl_rx_poisoned_err_tracker: RTL
===============================

# tl_rx_poisoned_err_tracker

Multi-channel poisoned-TLP checker and error logger for the TL RX write/completion path. For every received TLP it flags EP=1 as poisoned, gated by a per-channel enable, in the same cycle. It also keeps sticky status, saturating per-channel counts and a first-error header log. Logged errors are forwarded one at a time over a valid/ready handshake to the error-message generator, with round-robin arbitration across channels.

## Interface
Parameters:
- NUM_CH, 3, number of RX channels (0=P, 1=NP, 2=CPL by convention)
- CNT_W, 8, width of each per-channel poisoned-TLP counter
- HDR_W, 32, width of logged header fragment (first header DW)
- CH_W, $clog2(NUM_CH) (min 1), channel index width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- tlp_valid  in  NUM_CH  per-channel TLP header valid, one-cycle pulse per TLP
- tlp_ep  in  NUM_CH  EP bit of that TLP
- tlp_hdr  in  NUM_CH*HDR_W  header fragment; channel c at [c*HDR_W +: HDR_W]
- poisoned_en  in  NUM_CH  per-channel check enable
- clr_status  in  NUM_CH  write-1-to-clear for err_status and overflow
- poisoned_error  out  NUM_CH  combinational: tlp_valid & tlp_ep & poisoned_en
- err_status  out  NUM_CH  sticky "poisoned TLP received"
- overflow  out  NUM_CH  sticky "error dropped from log while one pending"
- err_cnt  out  NUM_CH*CNT_W  saturating poisoned count per channel
- msg_valid  out  1  report available
- msg_ready  in  1  consumer accepts report
- msg_ch  out  CH_W  channel of report
- msg_hdr  out  HDR_W  logged header of report

## Operation
- Event on channel c: ev[c] = tlp_valid[c] & tlp_ep[c] & poisoned_en[c]. poisoned_error = ev.
- On ev[c]: err_status[c] set; err_cnt[c] increments and holds at all-ones.
- Per-channel log: pending[c], hdr_log[c].
  - ev[c] with pending[c]=0: capture tlp_hdr and set pending.
  - ev[c] with pending[c]=1, not being retired this cycle: keep the original header; set overflow[c].
  - ev[c] in the same cycle as the handshake retiring c: capture the new header; pending stays 1; no overflow.
- clr_status[c] together with ev[c] in the same cycle: set wins. clr_status does not affect err_cnt or pending.
- Dropping poisoned_en[c] with pending[c]=1: the pending report is still delivered.
- FSM, states IDLE and REPORT:
  - IDLE: msg_valid=0. If any pending bit is set, a round-robin pick starting at rr_ptr latches sel; go to REPORT.
  - REPORT: msg_valid=1; msg_ch=sel; msg_hdr=hdr_log[sel].
  - REPORT with msg_ready=1: clear pending[sel] (unless recaptured); rr_ptr = sel+1 mod NUM_CH; go to IDLE.
- Reset values: all outputs 0 except poisoned_error, which is combinational. pending=0, hdr_log=0, rr_ptr=0, state=IDLE.

## Timing
- poisoned_error: 0-cycle latency.
- err_status, err_cnt, overflow, pending: update at the edge after ev.
- First msg_valid: 2 cycles after ev (pending is set at edge 1; IDLE→REPORT at edge 2).
- Throughput: at most 1 report per 2 cycles.
- While msg_valid=1 and msg_ready=0: msg_ch and msg_hdr stay stable. msg_valid never drops without a handshake, except on rst.
- rst mid-handshake: msg_valid=0 and all state cleared after that edge. A simultaneous msg_ready is ignored.

## Structure
- Package tl_rx_err_pkg holds:
  - state enum {IDLE, REPORT}
  - channel index constants CH_P=0, CH_NP=1, CH_CPL=2
- Sub-module tl_rx_rr_arbiter: NUM_CH request vector plus pointer in; one-hot grant and index out; combinational.

## Test plan
- Disabled channel: poisoned_en=3'b000, EP TLP on ch0 → poisoned_error=0, err_cnt[0]=0, no msg_valid.
- Single error: EP TLP on ch1 with hdr=32'hA5A5_0001, msg_ready=1 → poisoned_error[1]=1 same cycle; msg_valid 2 cycles later with msg_ch=1, msg_hdr=32'hA5A5_0001; err_cnt[1]=1; err_status[1]=1.
- Backpressure and overflow: msg_ready=0, two EP TLPs on ch0 (hdr 1, then 2) → msg_hdr stays 1; overflow[0]=1; err_cnt[0]=2. Raising msg_ready → one report, then msg_valid=0.
- Round-robin: simultaneous EP on ch0, ch1, ch2, msg_ready=1 → reports in order 0, 1, 2 on cycles 2, 4, 6.
- Saturation and clear: 300 EP TLPs on ch2 → err_cnt[2]=255. clr_status[2] pulse → err_status[2]=0 and overflow[2]=0; err_cnt[2] stays 255. clr_status and ev in the same cycle → err_status stays 1.
- Reset mid-report: rst asserted while msg_valid=1 → all outputs 0 next cycle; a fresh EP afterwards reports normally.

Source files
------------

// File: rtl/tl_rx_poisoned_err_tracker_pkg.sv
// Shared types and constants for the TL RX poisoned-TLP error tracker.
package tl_rx_err_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam int CH_P   = 0;
    localparam int CH_NP  = 1;
    localparam int CH_CPL = 2;

endpackage

// File: rtl/tl_rx_poisoned_err_tracker_if.sv
// Error-report channel from the tracker to the error-message generator.
// Handshake: a report transfers on a rising clk edge where msg_valid and msg_ready are both 1;
// once msg_valid rises, msg_ch/msg_hdr hold steady and msg_valid stays up until that transfer.
interface tl_rx_poisoned_err_tracker_if #(
    parameter int CH_W  = 2,
    parameter int HDR_W = 32
);
    logic             msg_valid;
    logic             msg_ready;
    logic [CH_W-1:0]  msg_ch;
    logic [HDR_W-1:0] msg_hdr;

    modport master (output msg_valid, output msg_ch, output msg_hdr, input msg_ready);
    modport slave  (input msg_valid, input msg_ch, input msg_hdr, output msg_ready);
endinterface

// File: rtl/tl_rx_poisoned_err_tracker_arb.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping at NUM_CH.
module tl_rx_rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o
);
    logic found;
    int   c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr_i) + i) % NUM_CH;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = CH_W'(c);
            end
        end
    end
endmodule

// File: rtl/tl_rx_poisoned_err_tracker.sv
// Poisoned-TLP detector with sticky status, saturating counts, a one-deep header log per
// channel and round-robin forwarding of logged errors over a valid/ready report channel.
module tl_rx_poisoned_err_tracker
    import tl_rx_err_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8,
    parameter int HDR_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         tlp_valid,
    input  logic [NUM_CH-1:0]         tlp_ep,
    input  logic [NUM_CH*HDR_W-1:0]   tlp_hdr,
    input  logic [NUM_CH-1:0]         poisoned_en,
    input  logic [NUM_CH-1:0]         clr_status,
    output logic [NUM_CH-1:0]         poisoned_error,
    output logic [NUM_CH-1:0]         err_status,
    output logic [NUM_CH-1:0]         overflow,
    output logic [NUM_CH*CNT_W-1:0]   err_cnt,
    tl_rx_poisoned_err_tracker_if.master msg_if,
    output state_t                    dbg_state
);
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [HDR_W-1:0]  hdr_q [NUM_CH];
    logic [HDR_W-1:0]  hdr_d [NUM_CH];

    state_t            state_q;
    logic              valid_q;
    logic [CH_W-1:0]   sel_q;
    logic [NUM_CH-1:0] sel_oh_q;
    logic [CH_W-1:0]   rr_q;

    logic              retire;
    logic [NUM_CH-1:0] retire_vec;
    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;

    assign ev             = tlp_valid & tlp_ep & poisoned_en;
    assign poisoned_error = ev;

    assign retire     = (state_q == REPORT) && msg_if.msg_ready;
    assign retire_vec = {NUM_CH{retire}} & sel_oh_q;

    tl_rx_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i  (pending_q),
        .ptr_i  (rr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // Sets beat clears; a retire coinciding with a new event recaptures instead of overflowing.
    always_comb begin
        status_d  = (status_q & ~clr_status) | ev;
        ovf_d     = (ovf_q & ~clr_status) | (ev & pending_q & ~retire_vec);
        pending_d = (pending_q & ~retire_vec) | ev;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            hdr_d[c] = hdr_q[c];
            if (ev[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
            if (ev[c] && (!pending_q[c] || retire_vec[c])) begin
                hdr_d[c] = tlp_hdr[c*HDR_W +: HDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            ovf_q     <= '0;
            pending_q <= '0;
            cnt_q     <= '{default: '0};
            hdr_q     <= '{default: '0};
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            sel_q     <= '0;
            sel_oh_q  <= '0;
            rr_q      <= '0;
        end else begin
            status_q  <= status_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        sel_q    <= arb_idx;
                        sel_oh_q <= arb_gnt;
                        valid_q  <= 1'b1;
                        state_q  <= REPORT;
                    end
                end
                REPORT: begin
                    if (msg_if.msg_ready) begin
                        rr_q    <= (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign err_status       = status_q;
    assign overflow         = ovf_q;
    assign msg_if.msg_valid = valid_q;
    assign msg_if.msg_ch    = sel_q;
    assign msg_if.msg_hdr   = hdr_q[sel_q];
    assign dbg_state        = state_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign err_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
endmodule
